digit_grid_renderer: RTL and testbench

- Pipelined, parametrised digit-grid locator for the VGA front end of the 24-game display.
- Per pixel (sx, sy), it decides which cell of a ROWS x COLS grid of digit cells the pixel falls in. It outputs that cell's digit, the pixel offsets within the cell, the cell index and a cursor highlight flag.
- Digit values are double-buffered and applied only at frame start, so the display never tears.
- Output feeds the existing seven-segment pixel generator.

---
 rtl/digit_grid_pkg.sv | 48 ++++
 rtl/grid_axis_decode.sv | 38 +++
 rtl/digit_grid_renderer.sv | 210 +++++++++++++++++++++
 tb/tb_digit_grid_renderer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digit_grid_pkg.sv
// Shared constants, types and geometry helpers for the digit grid renderer.
// Defaults describe the 24-game layout: 2 rows of 6 digit cells, in groups of 3.
package digit_grid_pkg;

  localparam int DEF_COLS         = 6;
  localparam int DEF_ROWS         = 2;
  localparam int DEF_COORD_W      = 10;
  localparam int DEF_DIGIT_W      = 4;
  localparam int DEF_X0           = 20;
  localparam int DEF_Y0           = 20;
  localparam int DEF_CELL_W       = 80;
  localparam int DEF_CELL_H       = 140;
  localparam int DEF_GAP_X        = 20;
  localparam int DEF_GAP_Y        = 40;
  localparam int DEF_GROUP        = 3;
  localparam int DEF_GROUP_GAP    = 20;
  localparam int DEF_BLINK_FRAMES = 30;

  // Width of an index able to name every one of n cells (at least 1 bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NCELLS = DEF_COLS * DEF_ROWS;
  localparam int IDX_W  = idx_width(NCELLS);

  typedef logic [IDX_W-1:0] cell_idx_t;

  // Leading edge of cell i along one axis; group <= 0 means no group gaps.
  function automatic int axis_edge(input int i, input int origin, input int size,
                                   input int gap, input int group, input int group_gap);
    int e;
    e = origin + i * (size + gap);
    if (group > 0) e = e + (i / group) * group_gap;
    return e;
  endfunction

  // Left edge of column c for the default layout.
  function automatic int col_left(input int c);
    return axis_edge(c, DEF_X0, DEF_CELL_W, DEF_GAP_X, DEF_GROUP, DEF_GROUP_GAP);
  endfunction

  // Top edge of row r for the default layout (rows have no grouping).
  function automatic int row_top(input int r);
    return axis_edge(r, DEF_Y0, DEF_CELL_H, DEF_GAP_Y, 0, 0);
  endfunction

endpackage

// File: rtl/grid_axis_decode.sv
// One-dimensional range decoder: which of COUNT half-open intervals holds coord,
// and the leading edge of that interval (0 when coord is in no interval).
// All interval bounds are elaboration-time constants, so each hit bit is a
// pair of constant comparisons.
module grid_axis_decode
  import digit_grid_pkg::*;
#(
  parameter int COUNT     = 6,
  parameter int ORIGIN    = 20,
  parameter int SIZE      = 80,
  parameter int GAP       = 20,
  parameter int GROUP     = 3,
  parameter int GROUP_GAP = 20,
  parameter int COORD_W   = 10
) (
  input  logic [COORD_W-1:0] coord,
  output logic [COUNT-1:0]   hit,
  output logic [COORD_W-1:0] cell_edge
);

  logic [COORD_W-1:0] edges [COUNT];

  for (genvar i = 0; i < COUNT; i++) begin : g_cell
    localparam int LO = axis_edge(i, ORIGIN, SIZE, GAP, GROUP, GROUP_GAP);
    localparam int HI = LO + SIZE;
    assign hit[i]   = (int'(coord) >= LO) && (int'(coord) < HI);
    assign edges[i] = COORD_W'(LO);
  end

  // Intervals never overlap, so at most one hit bit is set: OR-mux the edges.
  always_comb begin
    cell_edge = '0;
    for (int i = 0; i < COUNT; i++) begin
      if (hit[i]) cell_edge = cell_edge | edges[i];
    end
  end

endmodule

// File: rtl/digit_grid_renderer.sv
// Digit grid locator for the VGA front end: maps each pixel to a grid cell,
// its digit, in-cell offsets and a cursor highlight. Fixed 2-cycle latency.
// Digits are double-buffered and swapped only on frame_start.
// Optional macro DIGIT_GRID_BLINK_EN: cursor highlight blinks every
// BLINK_FRAMES frames; without it the highlight is steady.
module digit_grid_renderer
  import digit_grid_pkg::*;
#(
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int COORD_W      = DEF_COORD_W,
  parameter int DIGIT_W      = DEF_DIGIT_W,
  parameter int X0           = DEF_X0,
  parameter int Y0           = DEF_Y0,
  parameter int CELL_W       = DEF_CELL_W,
  parameter int CELL_H       = DEF_CELL_H,
  parameter int GAP_X        = DEF_GAP_X,
  parameter int GAP_Y        = DEF_GAP_Y,
  parameter int GROUP        = DEF_GROUP,
  parameter int GROUP_GAP    = DEF_GROUP_GAP,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES,
  localparam int NC = COLS * ROWS,
  localparam int IW = idx_width(NC)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_W-1:0]      sx,
  input  logic [COORD_W-1:0]      sy,
  input  logic                    pix_valid,
  input  logic                    frame_start,
  input  logic [NC*DIGIT_W-1:0]   numbers_in,
  input  logic                    load_req,
  output logic                    load_ack,
  input  logic [IW-1:0]           cursor,
  output logic                    out_valid,
  output logic                    in_cell,
  output logic [IW-1:0]           cell_index,
  output logic [DIGIT_W-1:0]      number,
  output logic [COORD_W-1:0]      sx_offset,
  output logic [COORD_W-1:0]      sy_offset,
  output logic                    highlight
);

  // Combinational axis decode of the incoming pixel
  logic [COLS-1:0]    col_hit;
  logic [ROWS-1:0]    row_hit;
  logic [COORD_W-1:0] x_edge;
  logic [COORD_W-1:0] y_edge;

  grid_axis_decode #(
    .COUNT(COLS), .ORIGIN(X0), .SIZE(CELL_W), .GAP(GAP_X),
    .GROUP(GROUP), .GROUP_GAP(GROUP_GAP), .COORD_W(COORD_W)
  ) u_x_decode (
    .coord(sx), .hit(col_hit), .cell_edge(x_edge)
  );

  grid_axis_decode #(
    .COUNT(ROWS), .ORIGIN(Y0), .SIZE(CELL_H), .GAP(GAP_Y),
    .GROUP(0), .GROUP_GAP(0), .COORD_W(COORD_W)
  ) u_y_decode (
    .coord(sy), .hit(row_hit), .cell_edge(y_edge)
  );

  // Stage 1 registers
  logic [COLS-1:0]    col_hit_q;
  logic [ROWS-1:0]    row_hit_q;
  logic [COORD_W-1:0] x_edge_q;
  logic [COORD_W-1:0] y_edge_q;
  logic [COORD_W-1:0] sx_q;
  logic [COORD_W-1:0] sy_q;
  logic               valid_q;

  // Digit banks
  logic [NC*DIGIT_W-1:0] active_bank;
  logic [NC*DIGIT_W-1:0] pending_bank;
  logic                  pending_flag;

  // Cursor visibility this frame (blink phase or constant)
  logic show_cursor;

  // Stage 2 combinational terms
  logic [IW-1:0]      col_sel;
  logic [IW-1:0]      row_sel;
  logic [IW-1:0]      idx_c;
  logic [DIGIT_W-1:0] digit_c;
  logic               hit_any;

  // Stage 1: capture hit vectors, edges, raw coordinates and valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_hit_q <= '0;
      row_hit_q <= '0;
      x_edge_q  <= '0;
      y_edge_q  <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      col_hit_q <= col_hit;
      row_hit_q <= row_hit;
      x_edge_q  <= x_edge;
      y_edge_q  <= y_edge;
      sx_q      <= sx;
      sy_q      <= sy;
      valid_q   <= pix_valid;
    end
  end

  // One-hot to index conversion and active-bank digit lookup
  always_comb begin
    col_sel = '0;
    for (int c = 0; c < COLS; c++) begin
      if (col_hit_q[c]) col_sel = IW'(c);
    end
    row_sel = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_hit_q[r]) row_sel = IW'(r);
    end
    idx_c   = IW'(int'(row_sel) * COLS + int'(col_sel));
    hit_any = (|col_hit_q) && (|row_hit_q);
    digit_c = '0;
    // Cell 0 lives in the most significant digit slot
    for (int k = 0; k < NC; k++) begin
      if (int'(idx_c) == k) digit_c = active_bank[(NC-1-k)*DIGIT_W +: DIGIT_W];
    end
  end

  // Stage 2: registered outputs, zeroed whenever the pixel misses every cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      in_cell    <= 1'b0;
      cell_index <= '0;
      number     <= '0;
      sx_offset  <= '0;
      sy_offset  <= '0;
      highlight  <= 1'b0;
    end else begin
      out_valid <= valid_q;
      if (hit_any) begin
        in_cell    <= 1'b1;
        cell_index <= idx_c;
        number     <= digit_c;
        sx_offset  <= sx_q - x_edge_q;
        sy_offset  <= sy_q - y_edge_q;
        highlight  <= (idx_c == cursor) && show_cursor;
      end else begin
        in_cell    <= 1'b0;
        cell_index <= '0;
        number     <= '0;
        sx_offset  <= '0;
        sy_offset  <= '0;
        highlight  <= 1'b0;
      end
    end
  end

  // Double-buffered digit load: swap on frame_start, ack one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_bank  <= '0;
      pending_bank <= '0;
      pending_flag <= 1'b0;
      load_ack     <= 1'b0;
    end else begin
      load_ack <= 1'b0;
      if (frame_start && load_req) begin
        // Request coincides with the frame boundary: bypass the pending bank
        active_bank  <= numbers_in;
        pending_flag <= 1'b0;
        load_ack     <= 1'b1;
      end else if (frame_start && pending_flag) begin
        active_bank  <= pending_bank;
        pending_flag <= 1'b0;
        load_ack     <= 1'b1;
      end else if (load_req) begin
        // A newer request simply overwrites the pending digits
        pending_bank <= numbers_in;
        pending_flag <= 1'b1;
      end
    end
  end

`ifdef DIGIT_GRID_BLINK_EN
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FCW-1:0] frame_cnt;
  logic           blink_phase;

  // Frame counter: toggle the blink phase every BLINK_FRAMES frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FCW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign show_cursor = blink_phase;
`else
  assign show_cursor = 1'b1;
`endif

endmodule

// File: tb/tb_digit_grid_renderer.sv
// Self-checking bench for digit_grid_renderer (BLINK_FRAMES overridden to 2).
// Expected values come from a geometry/bank/blink model written from the
// layout formulas, independent of the pipeline structure.
module tb_digit_grid_renderer;

  localparam int COLS = 6, ROWS = 2, CW = 10, DW = 4;
  localparam int X0 = 20, Y0 = 20, CELL_W = 80, CELL_H = 140;
  localparam int GAP_X = 20, GAP_Y = 40, GROUP = 3, GROUP_GAP = 20;
  localparam int BLINK = 2;
  localparam int NC = COLS * ROWS;
  localparam int IW = 4;
  localparam int VW = 1 + 1 + IW + DW + CW + CW + 1;

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n;
  logic [CW-1:0]  sx, sy;
  logic           pix_valid, frame_start, load_req;
  logic [NC*DW-1:0] numbers_in;
  logic           load_ack;
  logic [IW-1:0]  cursor;
  logic           out_valid, in_cell, highlight;
  logic [IW-1:0]  cell_index;
  logic [DW-1:0]  number;
  logic [CW-1:0]  sx_offset, sy_offset;

  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  digit_grid_renderer #(.BLINK_FRAMES(BLINK)) dut (
    .clk(clk), .rst_n(rst_n), .sx(sx), .sy(sy), .pix_valid(pix_valid),
    .frame_start(frame_start), .numbers_in(numbers_in), .load_req(load_req),
    .load_ack(load_ack), .cursor(cursor), .out_valid(out_valid),
    .in_cell(in_cell), .cell_index(cell_index), .number(number),
    .sx_offset(sx_offset), .sy_offset(sy_offset), .highlight(highlight)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int m_digit [NC];
  int m_pend  [NC];
  bit m_pend_flag;
  int m_frames;
  bit m_phase;

  function automatic void model_reset();
    for (int k = 0; k < NC; k++) begin
      m_digit[k] = 0;
      m_pend[k]  = 0;
    end
    m_pend_flag = 0;
    m_frames    = 0;
    m_phase     = 0;
  endfunction

  function automatic bit phase_on();
`ifdef DIGIT_GRID_BLINK_EN
    return m_phase;
`else
    return 1'b1;
`endif
  endfunction

  // Expected {out_valid, in_cell, cell_index, number, sx_offset, sy_offset, highlight}
  function automatic logic [VW-1:0] model_out(input int x, input int y, input bit v);
    bit hit = 0;
    int idx = 0, ox = 0, oy = 0, num = 0;
    bit hl = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        int xl, yt;
        xl = X0 + c * (CELL_W + GAP_X) + (c / GROUP) * GROUP_GAP;
        yt = Y0 + r * (CELL_H + GAP_Y);
        if (x >= xl && x < xl + CELL_W && y >= yt && y < yt + CELL_H) begin
          hit = 1; idx = r * COLS + c; ox = x - xl; oy = y - yt;
        end
      end
    end
    if (hit) begin
      num = m_digit[idx];
      hl  = (idx == int'(cursor)) && phase_on();
    end
    return {v, hit, IW'(idx), DW'(num), CW'(ox), CW'(oy), hl};
  endfunction

  function automatic logic [VW-1:0] observed();
    return {out_valid, in_cell, cell_index, number, sx_offset, sy_offset, highlight};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; pix_valid = 0; frame_start = 0; load_req = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Present one pixel, return what the outputs show two cycles later.
  task automatic send_pixel(input int x, input int y, output logic [VW-1:0] obs);
    @(negedge clk);
    sx = CW'(x); sy = CW'(y); pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0; sx = CW'($urandom_range(0, 1023)); sy = CW'($urandom_range(0, 1023));
    @(negedge clk);
    obs = observed();
  endtask

  task automatic do_load(input logic [NC*DW-1:0] v);
    @(negedge clk);
    load_req = 1'b1; numbers_in = v;
    @(negedge clk);
    load_req = 1'b0; numbers_in = '0;
    for (int k = 0; k < NC; k++) m_pend[k] = int'(v[(NC-1-k)*DW +: DW]);
    m_pend_flag = 1;
  endtask

  // Pulse frame_start (optionally with load_req); count ack cycles in a window.
  task automatic do_frame(input bit with_load, input logic [NC*DW-1:0] v,
                          output int acks, output bit ack_first, output int exp_acks);
    @(negedge clk);
    frame_start = 1'b1; load_req = with_load; numbers_in = v;
    exp_acks = 0;
    if (with_load) begin
      for (int k = 0; k < NC; k++) m_digit[k] = int'(v[(NC-1-k)*DW +: DW]);
      m_pend_flag = 0; exp_acks = 1;
    end else if (m_pend_flag) begin
      for (int k = 0; k < NC; k++) m_digit[k] = m_pend[k];
      m_pend_flag = 0; exp_acks = 1;
    end
    if (m_frames == BLINK - 1) begin
      m_frames = 0; m_phase = !m_phase;
    end else begin
      m_frames++;
    end
    @(negedge clk);
    frame_start = 1'b0; load_req = 1'b0; numbers_in = '0;
    acks = 0;
    ack_first = load_ack;
    for (int i = 0; i < 4; i++) begin
      if (load_ack === 1'b1) acks++;
      @(negedge clk);
    end
  endtask

  function automatic logic [NC*DW-1:0] rand_bank();
    logic [NC*DW-1:0] v;
    for (int k = 0; k < NC; k++) v[k*DW +: DW] = DW'($urandom_range(0, 15));
    return v;
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; sx = '0; sy = '0; pix_valid = 0; frame_start = 0;
    load_req = 0; numbers_in = '0; cursor = '0;
    model_reset();
    repeat (3) @(negedge clk);
    tests_run++;
    if (observed() !== '0 || load_ack !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %h ack=%b, expected 0", observed(), load_ack);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int xs [4] = '{19, 20, 99, 100};
    bit ic [4] = '{0, 1, 1, 0};
    logic [VW-1:0] obs, exp;
    for (int i = 0; i < 4; i++) begin
      send_pixel(xs[i], 20, obs);
      exp = model_out(xs[i], 20, 1);
      tests_run++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL sweep sx=%0d: got %h expected %h", xs[i], obs, exp);
      end
      tests_run++;
      if (obs[VW-2] !== ic[i]) begin
        fails++;
        $display("FAIL sweep_in_cell sx=%0d: got %b expected %b", xs[i], obs[VW-2], ic[i]);
      end
    end
  endtask

  task automatic test_group_gap();
    logic [VW-1:0] obs, exp;
    for (int x = 300; x < 340; x += 3) begin
      send_pixel(x, 20, obs);
      exp = model_out(x, 20, 1);
      tests_run++;
      if (obs !== exp || obs[VW-2] !== 1'b0) begin
        fails++;
        $display("FAIL group_gap sx=%0d: got %h expected %h", x, obs, exp);
      end
    end
    send_pixel(340, 200, obs);
    exp = model_out(340, 200, 1);
    tests_run++;
    if (obs !== exp || cell_index !== 4'd9 || sx_offset !== '0 || sy_offset !== '0) begin
      fails++;
      $display("FAIL group_cell9: got %h idx=%0d expected %h idx=9", obs, cell_index, exp);
    end
  endtask

  task automatic test_load();
    logic [NC*DW-1:0] v;
    logic [VW-1:0] obs, exp;
    int acks, exp_acks;
    bit first;
    for (int k = 0; k < NC; k++) v[(NC-1-k)*DW +: DW] = DW'(k + 1);
    do_load(v);
    send_pixel(540, 200, obs);
    exp = model_out(540, 200, 1);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL load_before_frame: got %h expected %h", obs, exp);
    end
    repeat (2) @(negedge clk);
    do_frame(0, '0, acks, first, exp_acks);
    tests_run++;
    if (acks !== exp_acks || first !== 1'b1) begin
      fails++;
      $display("FAIL load_ack: got %0d pulses first=%b expected %0d first=1", acks, first, exp_acks);
    end
    send_pixel(540, 200, obs);
    exp = model_out(540, 200, 1);
    tests_run++;
    if (obs !== exp || number !== 4'd12) begin
      fails++;
      $display("FAIL load_number12: got %h num=%0d expected %h num=12", obs, number, exp);
    end
  endtask

  task automatic test_double_load();
    logic [VW-1:0] obs, exp;
    int acks, exp_acks, x, y;
    bit first;
    do_load(rand_bank());
    do_load(rand_bank());
    do_frame(0, '0, acks, first, exp_acks);
    tests_run++;
    if (acks !== 1 || exp_acks !== 1 || first !== 1'b1) begin
      fails++;
      $display("FAIL double_load_ack: got %0d pulses expected 1", acks);
    end
    for (int k = 0; k < NC; k++) begin
      x = X0 + (k % COLS) * (CELL_W + GAP_X) + ((k % COLS) / GROUP) * GROUP_GAP + 5;
      y = Y0 + (k / COLS) * (CELL_H + GAP_Y) + 7;
      send_pixel(x, y, obs);
      exp = model_out(x, y, 1);
      tests_run++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL double_load_cell%0d: got %h expected %h", k, obs, exp);
      end
    end
    do_frame(0, '0, acks, first, exp_acks);
    tests_run++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL frame_no_pending: got %0d ack pulses expected 0", acks);
    end
    do_frame(1, rand_bank(), acks, first, exp_acks);
    tests_run++;
    if (acks !== 1 || first !== 1'b1) begin
      fails++;
      $display("FAIL same_cycle_load_ack: got %0d pulses first=%b expected 1", acks, first);
    end
    send_pixel(140, 230, obs);
    exp = model_out(140, 230, 1);
    tests_run++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL same_cycle_load_number: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_blink();
    bit pat [6] = '{0, 0, 1, 1, 0, 0};
    logic [VW-1:0] obs, exp;
    int acks, exp_acks, x, y;
    bit first, want;
    apply_reset();
    cursor = 4'd3;
    for (int f = 0; f < 6; f++) begin
      send_pixel(345, 30, obs);
      exp = model_out(345, 30, 1);
`ifdef DIGIT_GRID_BLINK_EN
      want = pat[f];
`else
      want = 1'b1;
`endif
      tests_run++;
      if (obs !== exp || highlight !== want) begin
        fails++;
        $display("FAIL blink frame%0d: got %h hl=%b expected %h hl=%b", f, obs, highlight, exp, want);
      end
      do_frame(0, '0, acks, first, exp_acks);
    end
    cursor = 4'd15;
    for (int f = 0; f < 4; f++) begin
      x = $urandom_range(0, 700); y = $urandom_range(0, 400);
      send_pixel(x, y, obs);
      exp = model_out(x, y, 1);
      tests_run++;
      if (obs !== exp || highlight !== 1'b0) begin
        fails++;
        $display("FAIL cursor15 (%0d,%0d): got %h expected %h", x, y, obs, exp);
      end
      do_frame(0, '0, acks, first, exp_acks);
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] exp, act;
    int x, y;
    bit v;
    do_frame(1, rand_bank(), x, v, y);
    cursor = IW'($urandom_range(0, NC - 1));
    for (int i = 0; i < 202; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        exp = exp_q.pop_front();
        act = observed();
        tests_run++;
        if (act !== exp) begin
          fails++;
          $display("FAIL stream cycle%0d: got %h expected %h", i, act, exp);
        end
      end
      if (i < 200) begin
        x = $urandom_range(0, 700); y = $urandom_range(0, 400); v = 1'($urandom_range(0, 1));
        sx = CW'(x); sy = CW'(y); pix_valid = v;
        exp_q.push_back(model_out(x, y, v));
      end else begin
        pix_valid = 1'b0;
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [VW-1:0] obs, exp;
    int acks, exp_acks;
    bit first;
    do_frame(1, rand_bank() | 48'h1, acks, first, exp_acks);
    do_load(rand_bank());
    cursor = 4'd0;
    @(negedge clk);
    sx = CW'(20); sy = CW'(20); pix_valid = 1'b1;
    repeat (3) @(negedge clk);
    exp = model_out(20, 20, 1);
    tests_run++;
    if (observed() !== exp) begin
      fails++;
      $display("FAIL pre_reset_pixel: got %h expected %h", observed(), exp);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (observed() !== '0 || load_ack !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got %h ack=%b expected 0", observed(), load_ack);
    end
    pix_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_frame(0, '0, acks, first, exp_acks);
    tests_run++;
    if (acks !== 0) begin
      fails++;
      $display("FAIL reset_drops_pending: got %0d ack pulses expected 0", acks);
    end
    send_pixel(20, 20, obs);
    exp = model_out(20, 20, 1);
    tests_run++;
    if (obs !== exp || number !== '0) begin
      fails++;
      $display("FAIL reset_active_bank: got %h num=%0d expected %h num=0", obs, number, exp);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_group_gap();
    test_load();
    test_double_load();
    test_blink();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
